// File: rtl/memory_responder.sv
// Fixed-latency backing store of 128-bit lines shared by the instruction and data cache
// controllers; round-robin arbitration, one transfer in flight, single-cycle ack per transfer.
`timescale 1ns/1ps
module memory_responder #(
   parameter int LATENCY   = 5,
   parameter int MEM_LINES = 4096,
   parameter int LINE_BITS = 128
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 i_req,
   input  logic [31:0]          i_addr,
   output logic                 i_ack,
   output logic [LINE_BITS-1:0] i_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [31:0]          d_addr,
   input  logic [LINE_BITS-1:0] d_wdata,
   output logic                 d_ack,
   output logic [LINE_BITS-1:0] d_rdata,
   output logic                 busy
);

   localparam int IDX_W = $clog2(MEM_LINES);
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 rr_d_q, rr_d_d;     // 1: data port wins the next tie
   logic                 port_q, port_d;     // 1: data port owns the transfer
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 we_q, we_d;
   logic [LINE_BITS-1:0] wdata_q, wdata_d;
   logic [LINE_BITS-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_BITS-1:0] d_rdata_q, d_rdata_d;
   logic                 pick_d;
   logic                 mem_we;
   logic [LINE_BITS-1:0] mem_rd;

   logic [LINE_BITS-1:0] mem_q [MEM_LINES];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[31:IDX_W+4], i_addr[3:0], d_addr[31:IDX_W+4], d_addr[3:0]};

   assign mem_rd = mem_q[idx_q];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rr_d_d    = rr_d_q;
      port_d    = port_q;
      idx_d     = idx_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      pick_d    = 1'b0;
      mem_we    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               pick_d  = d_req && (!i_req || rr_d_q);
               port_d  = pick_d;
               idx_d   = pick_d ? d_addr[IDX_W+3:4] : i_addr[IDX_W+3:4];
               we_d    = pick_d && d_we;
               wdata_d = d_wdata;
               cnt_d   = CNT_W'(LATENCY - 2);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               // Read data is captured on the way into ACK so it is stable for the whole ack cycle.
               state_d = ACK;
               if (port_q) begin
                  d_rdata_d = we_q ? wdata_q : mem_rd;
               end else begin
                  i_rdata_d = mem_rd;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ACK: begin
            mem_we  = we_q;
            rr_d_d  = !port_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rr_d_q    <= 1'b0;
         port_q    <= 1'b0;
         idx_q     <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rr_d_q    <= rr_d_d;
         port_q    <= port_d;
         idx_q     <= idx_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // Store is never reset; a reset during a transfer drops state_q to IDLE so mem_we never fires.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

   assign i_ack   = (state_q == ACK) && !port_q;
   assign d_ack   = (state_q == ACK) && port_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: stimulus queues expected acks, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_memory_responder;

   localparam int LAT = 5;
   localparam logic [127:0] W1 = 128'h11112222_33334444_55556666_77778888;
   localparam logic [127:0] W2 = 128'hDEADBEEF_00000004_CAFEF00D_44444444;
   localparam logic [127:0] W3 = 128'hBADBADBA_DBADBADB_ADBADBAD_BADBAD33;
   localparam logic [127:0] W4 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   logic         clock = 1'b0;
   logic         reset;
   logic         i_req, d_req, d_we;
   logic [31:0]  i_addr, d_addr;
   logic [127:0] d_wdata;
   logic         i_ack, d_ack, busy;
   logic [127:0] i_rdata, d_rdata;

   logic         i_req2;
   logic [31:0]  i_addr2;
   logic         i_ack2, d_ack2, busy2;
   logic [127:0] i_rdata2, d_rdata2;

   memory_responder #(.LATENCY(LAT)) u_dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy)
   );

   memory_responder #(.LATENCY(2)) u_dut2 (
      .clock(clock), .reset(reset),
      .i_req(i_req2), .i_addr(i_addr2), .i_ack(i_ack2), .i_rdata(i_rdata2),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(128'h0),
      .d_ack(d_ack2), .d_rdata(d_rdata2), .busy(busy2)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int           port;   // 0: i (LAT), 1: d (LAT), 2: i of LATENCY=2 instance
      logic [127:0] data;
      bit           chk;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_ack(input int port, input logic [127:0] data, input bit chk, input int at);
      exp_t e;
      e.port = port;
      e.data = data;
      e.chk  = chk;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   // Monitor
   always @(negedge clock) begin
      int   p;
      exp_t e;
      if (i_ack && d_ack) check("one_ack_per_cycle", 128'(1), 128'(0));
      if (i_ack || d_ack || i_ack2) begin
         p = i_ack2 ? 2 : (d_ack ? 1 : 0);
         if (exp_q.size() == 0) begin
            check("unexpected_ack_port", 128'(p), 128'(99));
         end else begin
            e = exp_q.pop_front();
            check("ack_port", 128'(p), 128'(e.port));
            check("ack_cycle", 128'(cyc), 128'(e.cyc));
            if (e.chk) check("ack_data", (p == 1) ? d_rdata : i_rdata, e.data);
         end
      end
   end

   // Hold requests until the given number of acks per port, deasserting in the cycle after the last one.
   task automatic run_until(input int ni, input int nd);
      int gi = 0;
      int gd = 0;
      for (int k = 0; k < 80 && (gi < ni || gd < nd); k++) begin
         @(negedge clock);
         if (i_ack) gi++;
         if (d_ack) gd++;
         @(posedge clock); #1;
         if (gi >= ni) i_req = 1'b0;
         if (gd >= nd) d_req = 1'b0;
      end
      check("acks_seen", 128'(gi + gd), 128'(ni + nd));
   endtask

   task automatic d_txn(input bit we, input logic [31:0] addr, input logic [127:0] wd,
                        input logic [127:0] exp_data);
      int c;
      c = cyc;
      d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1;
      expect_ack(1, exp_data, 1'b1, c + LAT);
      run_until(0, 1);
   endtask

   task automatic i_txn(input logic [31:0] addr, input logic [127:0] exp_data);
      int c;
      c = cyc;
      i_addr = addr; i_req = 1'b1;
      expect_ack(0, exp_data, 1'b1, c + LAT);
      run_until(1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      reset = 1'b0;
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      i_addr = '0; d_addr = '0; d_wdata = '0;
      i_req2 = 1'b0; i_addr2 = '0;

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_i_ack", 128'(i_ack), 128'(0));
      check("rst_d_ack", 128'(d_ack), 128'(0));
      check("rst_i_rdata", i_rdata, 128'(0));
      check("rst_d_rdata", d_rdata, 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      // Single read: timing and busy window
      c = cyc;
      i_addr = 32'h40; i_req = 1'b1;
      expect_ack(0, '0, 1'b0, c + LAT);
      for (int k = 0; k <= LAT + 1; k++) begin
         @(negedge clock);
         check("busy_window", 128'(busy), 128'(k >= 1 && k <= LAT));
         @(posedge clock); #1;
         if (k == LAT) i_req = 1'b0;
      end

      // Write then read back on the data port (write ack echoes the line)
      d_txn(1'b1, 32'h100, W1, W1);
      d_txn(1'b0, 32'h100, '0, W1);

      // Data-port write, instruction-port read of the same line
      d_txn(1'b1, 32'h40, W2, W2);
      d_txn(1'b0, 32'h0, '0, '0);
      i_txn(32'h40, W2);

      // Reset while a write is in flight: no ack, outputs cleared, write dropped
      c = cyc;
      d_we = 1'b1; d_addr = 32'h100; d_wdata = W3; d_req = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(negedge clock);
      check("midrst_i_ack", 128'(i_ack), 128'(0));
      check("midrst_d_ack", 128'(d_ack), 128'(0));
      check("midrst_i_rdata", i_rdata, 128'(0));
      check("midrst_d_rdata", d_rdata, 128'(0));
      check("midrst_busy", 128'(busy), 128'(0));
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;

      // Contention after reset: i first, then d; i re-requests immediately and waits behind d.
      // The d read of 0x100 returning W1 also shows the aborted write never landed.
      c = cyc;
      i_addr = 32'h40;  i_req = 1'b1;
      d_addr = 32'h100; d_we = 1'b0; d_req = 1'b1;
      expect_ack(0, W2, 1'b1, c + LAT);
      expect_ack(1, W1, 1'b1, c + 2 * LAT + 1);
      expect_ack(0, W2, 1'b1, c + 3 * LAT + 2);
      run_until(2, 1);

      // Aliasing: 0x10010 wraps onto line 1 with 4096 lines
      d_txn(1'b1, 32'h10, W4, W4);
      i_txn(32'h0001_0010, W4);
      d_txn(1'b0, 32'hFFFF_0010, '0, W4);

      // LATENCY=2 instance: held request yields acks in cycles 2 and 5
      c = cyc;
      i_addr2 = 32'h40; i_req2 = 1'b1;
      expect_ack(2, '0, 1'b0, c + 2);
      expect_ack(2, '0, 1'b0, c + 5);
      repeat (6) @(posedge clock);
      #1;
      i_req2 = 1'b0;

      repeat (10) @(posedge clock);
      #1;
      check("expected_acks_outstanding", 128'(exp_q.size()), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
